// File: rtl/boron_key_schedule_if.sv
// ---------------------------------------------------------------------------
// boron_key_schedule_if
// Handshake bundle between the BORON key schedule and its neighbours.
//   key_in/key_load/key_ready : master-key load handshake (into the schedule)
//   round_key/rk_valid/rk_ready: round-key stream (out of the schedule)
//   rk_round/rk_last           : index of the presented key, last-key flag
//   done                       : one-cycle pulse after the final key is taken
// master = key schedule side, slave = key source / round datapath side.
// ---------------------------------------------------------------------------
interface boron_key_schedule_if #(
    parameter int CNT_W = 5
);
    logic [79:0]      key_in;
    logic             key_load;
    logic             key_ready;
    logic [63:0]      round_key;
    logic             rk_valid;
    logic             rk_ready;
    logic [CNT_W-1:0] rk_round;
    logic             rk_last;
    logic             done;

    modport master (
        input  key_in, key_load, rk_ready,
        output key_ready, round_key, rk_valid, rk_round, rk_last, done
    );

    modport slave (
        output key_in, key_load, rk_ready,
        input  key_ready, round_key, rk_valid, rk_round, rk_last, done
    );
endinterface

// File: rtl/boron_key_schedule.sv
// ---------------------------------------------------------------------------
// boron_key_schedule
// Round-key generator for the BORON cipher (64-bit block, 80-bit key).
// Loads an 80-bit master key, then presents RK0..RK(ROUNDS) one at a time on
// a valid/ready stream; the key register advances only when a key is taken.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-low reset
//   ks  : boron_key_schedule_if.master (load handshake + round-key stream)
// All outputs decode registered state only; key_load and rk_ready never reach
// an output combinationally.
// ---------------------------------------------------------------------------
module boron_key_schedule #(
    parameter int ROUNDS = 25,
    parameter int CNT_W  = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    boron_key_schedule_if.master   ks
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [79:0]      key_q,   key_d;
    logic [CNT_W-1:0] r_q,     r_d;
    logic [CNT_W-1:0] r_next;
    logic             at_last;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hE;  4'h1: y = 4'h4;  4'h2: y = 4'hB;  4'h3: y = 4'h1;
            4'h4: y = 4'h7;  4'h5: y = 4'h9;  4'h6: y = 4'hC;  4'h7: y = 4'hA;
            4'h8: y = 4'hD;  4'h9: y = 4'h2;  4'hA: y = 4'h0;  4'hB: y = 4'hF;
            4'hC: y = 4'h8;  4'hD: y = 4'h5;  4'hE: y = 4'h3;  default: y = 4'h6;
        endcase
        return y;
    endfunction

    // Rotate, then S-box the low nibble of the rotated value, then inject the
    // round constant; order matters because the rotate moves bits into [3:0].
    function automatic logic [79:0] key_update(input logic [79:0] k,
                                               input logic [4:0]  c);
        logic [79:0] t;
        t        = {k[66:0], k[79:67]};
        t[3:0]   = sbox(t[3:0]);
        t[63:59] = t[63:59] ^ c;
        return t;
    endfunction

    assign r_next  = r_q + 1'b1;
    assign at_last = (r_q == CNT_W'(ROUNDS));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        r_d          = r_q;
        ks.key_ready = 1'b0;
        ks.rk_valid  = 1'b0;
        ks.done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                ks.key_ready = 1'b1;
                if (ks.key_load) begin
                    key_d   = ks.key_in;
                    r_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                ks.rk_valid = 1'b1;
                if (ks.rk_ready) begin
                    // The final key is consumed without touching K, so the
                    // register still shows RK(ROUNDS) afterwards.
                    if (at_last) begin
                        state_d = S_DONE;
                    end else begin
                        key_d = key_update(key_q, r_next[4:0]);
                        r_d   = r_next;
                    end
                end
            end
            S_DONE: begin
                ks.done = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ks.round_key = key_q[63:0];
    assign ks.rk_round  = r_q;
    assign ks.rk_last   = (state_q == S_RUN) && at_last;

endmodule

// File: tb/tb_boron_key_schedule.sv
module tb_boron_key_schedule;

    localparam int ROUNDS = 25;
    localparam int CNT_W  = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;

    boron_key_schedule_if #(.CNT_W(CNT_W)) bus ();

    boron_key_schedule #(.ROUNDS(ROUNDS), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .ks  (bus)
    );

    always #5 clk = ~clk;

    int          pass_cnt = 0;
    int          chk_cnt  = 0;
    logic [63:0] obs [0:ROUNDS];
    int          cyc_used;

    localparam logic [79:0] KEY_ONES = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [79:0] KEY_R1   = 80'h3A5C_96E1_0F7B_D248_C13E;
    localparam logic [79:0] KEY_R2   = 80'h0123_4567_89AB_CDEF_F00D;
    localparam logic [79:0] KEY_R3   = 80'hDEAD_BEEF_CAFE_1234_5678;

    // Reference key update, written as a bit-level rotate plus table lookup.
    function automatic logic [79:0] f_upd(input logic [79:0] k, input logic [4:0] c);
        logic [3:0]  tbl [0:15];
        logic [79:0] t;
        tbl = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};
        for (int i = 0; i < 80; i++) t[(i + 13) % 80] = k[i];
        t[3:0] = tbl[t[3:0]];
        for (int i = 0; i < 5; i++) t[59 + i] = t[59 + i] ^ c[i];
        return t;
    endfunction

    task automatic load_key(input logic [79:0] k);
        chk_cnt++;
        if (bus.key_ready !== 1'b1)
            $display("FAIL load_ready: key_ready got %b want 1", bus.key_ready);
        else pass_cnt++;
        bus.key_in   = k;
        bus.key_load = 1'b1;
        @(negedge clk);
        bus.key_load = 1'b0;
    endtask

    // Walks the key stream from the current cycle. mode 0: always ready,
    // 1: random ready, 2: 5-cycle stall at r=3, 3: stray key_load at r=5.
    // stop_at <= ROUNDS abandons the stream when that index is presented.
    task automatic collect_keys(input logic [79:0] key, input int mode,
                                input int stop_at, input logic [79:0] alt_key);
        logic [79:0] m;
        logic [72:0] got, exp;
        int          r, cyc, stall;
        logic        rdy;
        m = key; r = 0; cyc = 0; stall = 0;
        while (r <= ROUNDS && cyc < 1000) begin
            if (r == stop_at) break;
            got = {bus.rk_valid, bus.key_ready, bus.round_key, bus.rk_round, bus.rk_last, bus.done};
            exp = {1'b1, 1'b0, m[63:0], 5'(r), (r == ROUNDS), 1'b0};
            chk_cnt++;
            if (got !== exp)
                $display("FAIL stream r=%0d mode=%0d: got %h want %h", r, mode, got, exp);
            else pass_cnt++;
            obs[r] = bus.round_key;
            case (mode)
                1:       rdy = 1'($urandom_range(0, 1));
                2:       if (r == 3 && stall < 5) begin rdy = 1'b0; stall++; end
                         else rdy = 1'b1;
                default: rdy = 1'b1;
            endcase
            bus.key_load = (mode == 3 && r == 5);
            bus.key_in   = (mode == 3 && r == 5) ? alt_key : key;
            bus.rk_ready = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) begin
                if (r < ROUNDS) m = f_upd(m, 5'(r + 1));
                r++;
            end
        end
        bus.key_load = 1'b0;
        bus.rk_ready = 1'b0;
        cyc_used     = cyc;
        if (cyc >= 1000) begin
            chk_cnt++;
            $display("FAIL stream_timeout: reached r=%0d want %0d", r, ROUNDS + 1);
        end else if (stop_at > ROUNDS) begin
            chk_cnt++;
            if ({bus.done, bus.rk_valid, bus.rk_last, bus.key_ready} !== 4'b1000)
                $display("FAIL done_pulse: done/valid/last/ready got %b want 1000",
                         {bus.done, bus.rk_valid, bus.rk_last, bus.key_ready});
            else pass_cnt++;
        end
    endtask

    task automatic finish_idle();
        @(negedge clk);
        chk_cnt++;
        if ({bus.done, bus.rk_valid, bus.key_ready} !== 3'b001)
            $display("FAIL idle_after_done: done/valid/ready got %b want 001",
                     {bus.done, bus.rk_valid, bus.key_ready});
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b0; bus.key_load = 1'b0; bus.rk_ready = 1'b0; bus.key_in = '0;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if ({bus.key_ready, bus.rk_valid, bus.rk_last, bus.done, bus.round_key, bus.rk_round}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 5'd0})
            $display("FAIL reset_state: ready/valid/last/done got %b%b%b%b key %h round %0d want 1000 0 0",
                     bus.key_ready, bus.rk_valid, bus.rk_last, bus.done, bus.round_key, bus.rk_round);
        else pass_cnt++;
        rst = 1'b1;
    endtask

    task automatic test_zero_key();
        load_key(80'h0);
        collect_keys(80'h0, 0, 99, 80'h0);
        chk_cnt++;
        if (cyc_used !== 26) $display("FAIL zero_cycles: got %0d want 26", cyc_used);
        else pass_cnt++;
        chk_cnt++;
        if (obs[0] !== 64'h0) $display("FAIL zero_rk0: got %h want 0", obs[0]);
        else pass_cnt++;
        chk_cnt++;
        if (obs[1] !== 64'h0800_0000_0000_000E)
            $display("FAIL zero_rk1: got %h want 0800_0000_0000_000E", obs[1]);
        else pass_cnt++;
        chk_cnt++;
        if (obs[2] !== 64'h1000_0000_0001_C00E)
            $display("FAIL zero_rk2: got %h want 1000_0000_0001_C00E", obs[2]);
        else pass_cnt++;
        finish_idle();
    endtask

    task automatic test_golden();
        load_key(KEY_ONES);
        collect_keys(KEY_ONES, 0, 99, 80'h0);
        chk_cnt++;
        if (obs[1] !== 64'hF7FF_FFFF_FFFF_FFF6)
            $display("FAIL ones_rk1: got %h want F7FF_FFFF_FFFF_FFF6", obs[1]);
        else pass_cnt++;
        finish_idle();
        load_key(KEY_R1);
        collect_keys(KEY_R1, 0, 99, 80'h0);
        finish_idle();
    endtask

    task automatic test_backpressure();
        load_key(KEY_R2);
        collect_keys(KEY_R2, 2, 99, 80'h0);
        chk_cnt++;
        if (cyc_used !== 31) $display("FAIL stall_cycles: got %0d want 31", cyc_used);
        else pass_cnt++;
        finish_idle();
        load_key(KEY_R2);
        collect_keys(KEY_R2, 1, 99, 80'h0);
        finish_idle();
    endtask

    task automatic test_ignored_load();
        load_key(KEY_R1);
        collect_keys(KEY_R1, 3, 99, KEY_ONES);
        finish_idle();
    endtask

    task automatic test_mid_reset();
        load_key(KEY_R3);
        collect_keys(KEY_R3, 0, 10, 80'h0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk_cnt++;
        if ({bus.rk_valid, bus.key_ready, bus.done, bus.round_key} !== {1'b0, 1'b1, 1'b0, 64'h0})
            $display("FAIL mid_reset: valid/ready/done got %b%b%b key %h want 010 0",
                     bus.rk_valid, bus.key_ready, bus.done, bus.round_key);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if ({bus.done, bus.key_ready} !== 2'b01)
            $display("FAIL mid_reset_nodone: done/ready got %b want 01", {bus.done, bus.key_ready});
        else pass_cnt++;
        load_key(KEY_R3);
        collect_keys(KEY_R3, 0, 99, 80'h0);
        finish_idle();
    endtask

    task automatic test_back_to_back();
        load_key(KEY_R2);
        collect_keys(KEY_R2, 0, 99, 80'h0);
        // Now in the done cycle: this load must be dropped.
        bus.key_in   = KEY_ONES;
        bus.key_load = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if ({bus.rk_valid, bus.key_ready} !== 2'b01)
            $display("FAIL b2b_first_ignored: valid/ready got %b want 01", {bus.rk_valid, bus.key_ready});
        else pass_cnt++;
        bus.key_in = KEY_R1;
        @(negedge clk);
        bus.key_load = 1'b0;
        collect_keys(KEY_R1, 0, 99, 80'h0);
        finish_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.key_in   = '0;
        bus.key_load = 1'b0;
        bus.rk_ready = 1'b0;
        test_reset();
        test_zero_key();
        test_golden();
        test_backpressure();
        test_ignored_load();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
